// File: rtl/store_buffer.sv
// Posted-write store buffer between the core data port and a slower data RAM.
// Core stores queue in a circular FIFO, drain to the RAM and forward to loads.
module store_buffer #(
  parameter int SIZE       = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 4
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic [ADDR_WIDTH-1:0]        daddr,
  input  logic [SIZE-1:0]              ddata_w,
  input  logic                         d_rw,
  output logic [SIZE-1:0]              ddata_r,
  output logic                         stall,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count,
  output logic [ADDR_WIDTH-1:0]        mem_waddr,
  output logic [SIZE-1:0]              mem_wdata,
  output logic                         mem_we,
  input  logic                         mem_wack,
  output logic [ADDR_WIDTH-1:0]        mem_raddr,
  input  logic [SIZE-1:0]              mem_rdata,
  output logic                         drain_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} drain_t;

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [SIZE-1:0]       data_q [DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_next;
  logic                  full;
  logic                  enq;
  logic                  pop;
  drain_t                state;
  drain_t                state_next;
  logic                  fwd_hit;
  logic [SIZE-1:0]       fwd_data;
  logic [PW-1:0]         fwd_idx;

  // Full is judged on the cycle-start count, so a slot freed by this
  // cycle's pop only becomes usable on the next cycle.
  assign full  = (count_q == CW'(DEPTH));
  assign enq   = d_rw & ~full;
  assign stall = d_rw & full;
  assign empty = (count_q == '0);
  assign count = count_q;

  // RAM handshake: mem_we is the request and stays high with a stable
  // head address/data until mem_wack; a cycle with both high is one write.
  assign pop = (state == WRITE) & mem_wack;

  always_ff @(posedge CLK) begin
    if (enq) begin
      addr_q[tail] <= daddr;
      data_q[tail] <= ddata_w;
    end
  end

  always_comb begin
    count_next = count_q;
    case ({enq, pop})
      2'b10:   count_next = count_q + CW'(1);
      2'b01:   count_next = count_q - CW'(1);
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (pop) head <= head + PW'(1);
      count_q <= count_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count_next != '0) state_next = WRITE;
      WRITE:   if (count_next == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_we      = (state == WRITE);
    drain_state = state;
    mem_waddr   = addr_q[head];
    mem_wdata   = data_q[head];
  end

  // Walk from oldest to youngest so the last match wins; an entry being
  // popped is still counted, a store enqueued this cycle is not yet.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[fwd_idx] == daddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  assign mem_raddr = daddr;
  assign ddata_r   = fwd_hit ? fwd_data : mem_rdata;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic against a
// queue-based model of pending stores and an array model of the RAM.
module tb_store_buffer;

  localparam int SIZE  = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [AW-1:0]   a;
    logic [SIZE-1:0] d;
  } ent_t;

  logic            CLK = 1'b0;
  logic            RESET_N = 1'b0;
  logic [AW-1:0]   daddr = '0;
  logic [SIZE-1:0] ddata_w = '0;
  logic            d_rw = 1'b0;
  logic [SIZE-1:0] ddata_r;
  logic            stall;
  logic            empty;
  logic [CW-1:0]   count;
  logic [AW-1:0]   mem_waddr;
  logic [SIZE-1:0] mem_wdata;
  logic            mem_we;
  logic            mem_wack = 1'b0;
  logic [AW-1:0]   mem_raddr;
  logic [SIZE-1:0] mem_rdata;
  logic            drain_state;

  logic [SIZE-1:0] ram [0:(1<<AW)-1];
  ent_t            exp_q[$];
  int              total = 0;
  int              bad = 0;

  store_buffer #(.SIZE(SIZE), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .daddr(daddr), .ddata_w(ddata_w),
    .d_rw(d_rw), .ddata_r(ddata_r), .stall(stall), .empty(empty),
    .count(count), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_wack(mem_wack), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .drain_state(drain_state)
  );

  always #5 CLK = ~CLK;

  assign mem_rdata = ram[mem_raddr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One core cycle: drive, check combinational outputs against the model,
  // then advance the model and the RAM across the rising edge.
  task automatic step(input logic rw, input logic [AW-1:0] a,
                      input logic [SIZE-1:0] d, input logic wack);
    logic [SIZE-1:0] exp_r;
    logic            we_o;
    logic [AW-1:0]   wa_o;
    logic [SIZE-1:0] wd_o;
    int              n;
    @(negedge CLK);
    d_rw = rw; daddr = a; ddata_w = d; mem_wack = wack;
    #1;
    n = exp_q.size();
    exp_r = ram[a];
    foreach (exp_q[i]) if (exp_q[i].a == a) exp_r = exp_q[i].d;
    chk("count", 64'(count), 64'(n));
    chk("empty", 64'(empty), 64'(n == 0));
    chk("mem_we", 64'(mem_we), 64'(n != 0));
    chk("drain_state", 64'(drain_state), 64'(n != 0));
    chk("stall", 64'(stall), 64'(rw && n == DEPTH));
    chk("ddata_r", 64'(ddata_r), 64'(exp_r));
    chk("mem_raddr", 64'(mem_raddr), 64'(a));
    if (n != 0) begin
      chk("mem_waddr", 64'(mem_waddr), 64'(exp_q[0].a));
      chk("mem_wdata", 64'(mem_wdata), 64'(exp_q[0].d));
    end
    we_o = mem_we; wa_o = mem_waddr; wd_o = mem_wdata;
    @(posedge CLK);
    if (we_o && wack) ram[wa_o] = wd_o;
    if (n != 0 && wack) void'(exp_q.pop_front());
    if (rw && n < DEPTH) exp_q.push_back({a, d});
  endtask

  task automatic do_reset(input logic wack);
    @(negedge CLK);
    RESET_N = 1'b0; d_rw = 1'b0; mem_wack = wack;
    @(posedge CLK);
    exp_q.delete();
    #1;
    RESET_N = 1'b1;
  endtask

  initial begin
    logic [SIZE-1:0] d5;
    for (int i = 0; i < (1 << AW); i++) ram[i] = $urandom;
    ram[0]     = 32'hCAFEBABE;
    ram['h010] = 32'h0;

    do_reset(1'b0);
    step(1'b0, 10'h000, '0, 1'b0);
    step(1'b0, 10'h000, '0, 1'b1);

    // single store, forwarded while pending, then one ack
    step(1'b1, 10'h010, 32'h12345678, 1'b0);
    step(1'b0, 10'h010, '0, 1'b0);
    step(1'b0, 10'h010, '0, 1'b1);
    step(1'b0, 10'h010, '0, 1'b0);

    // fill, stall on the fifth store, release with one ack
    for (int i = 0; i < 4; i++) step(1'b1, AW'('h100 + i), $urandom, 1'b0);
    d5 = $urandom;
    step(1'b1, 10'h104, d5, 1'b0);
    step(1'b1, 10'h104, d5, 1'b1);
    step(1'b1, 10'h104, d5, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 10'h104, '0, 1'b1);

    // same-address stores drain in order; loads see youngest pending
    step(1'b1, 10'h020, 32'h1, 1'b1);
    step(1'b1, 10'h020, 32'h2, 1'b1);
    step(1'b1, 10'h020, 32'h3, 1'b1);
    step(1'b0, 10'h020, '0, 1'b1);
    step(1'b0, 10'h020, '0, 1'b1);
    step(1'b0, 10'h020, '0, 1'b0);

    // wrap-around with ack every other cycle
    for (int i = 0; i < 10; i++) step(1'b1, AW'('h200 + i), $urandom, 1'(i % 2));
    for (int i = 0; i < 8; i++) step(1'b0, AW'('h200 + i), '0, 1'b1);

    // reset mid-drain discards pending stores
    for (int i = 0; i < 3; i++) step(1'b1, AW'('h280 + i), $urandom, 1'b0);
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, AW'('h280 + i), '0, 1'b1);

    // random traffic over a small address window
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), AW'($urandom_range('h300, 'h307)),
           $urandom, 1'($urandom_range(0, 1)));
    do_reset(1'($urandom_range(0, 1)));
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), AW'($urandom_range('h300, 'h303)),
           $urandom, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 8; i++) step(1'b0, AW'($urandom_range('h300, 'h303)), '0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
